filt_oup_sink: RTL and testbench

//  Receive end of the filt_mac output interface. Captures each full-precision filter result qualified by its done strobe.

---
 rtl/filt_sink_pkg.sv | 20 ++
 rtl/filt_sink_fifo.sv | 60 ++++++
 rtl/filt_oup_sink.sv | 97 +++++++++
 tb/tb_filt_oup_sink.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_sink_pkg.sv
// rtl/filt_sink_pkg.sv - shared helpers for filt_oup_sink: pointer width, rounding constant, saturation limits
package filt_sink_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [63:0] round_const(input int shift);
        return (shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/filt_sink_fifo.sv
// rtl/filt_sink_fifo.sv - synchronous FIFO with push/pop, full/empty flags and occupancy level
module filt_sink_fifo
    import filt_sink_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      level
);

    localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign rd_en = pop && !empty;
    // A write at full is only safe when the head slot is freed in the same cycle.
    assign wr_en = push && (!full || rd_en);

    assign full     = (count == FULL_LVL);
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/filt_oup_sink.sv
// rtl/filt_oup_sink.sv - rescale/saturate filter results into a FIFO-backed valid/ready stream
// Optional FILT_SINK_ROUND_EN: round half-up before the rescaling shift.
module filt_oup_sink
    import filt_sink_pkg::*;
#(
    parameter int gp_inp_width  = 37,
    parameter int gp_oup_width  = 16,
    parameter int gp_shift      = 12,
    parameter int gp_fifo_depth = 4,
    localparam int LW = ptr_width(gp_fifo_depth) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [gp_inp_width-1:0] i_data,
    input  logic                    i_done,
    output logic [gp_oup_width-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [LW-1:0]           o_level,
    output logic                    o_ovf,
    output logic                    o_drop
);

    localparam int XW = gp_inp_width + 1;
    localparam logic signed [63:0] SAT_MAX = sat_max(gp_oup_width);
    localparam logic signed [63:0] SAT_MIN = sat_min(gp_oup_width);

    logic signed [XW-1:0] data_ext;
    logic signed [XW-1:0] sum;
    logic signed [XW-1:0] s1_data;
    logic                 s1_valid;
    logic signed [63:0]   s1_wide;
    logic                 clip_hi;
    logic                 clip_lo;
    logic [gp_oup_width-1:0] sat_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop_now;

    assign data_ext = {i_data[gp_inp_width-1], i_data};

`ifdef FILT_SINK_ROUND_EN
    localparam logic [63:0] RND64 = round_const(gp_shift);
    localparam logic signed [XW-1:0] RND = RND64[XW-1:0];
    assign sum = data_ext + RND;
`else
    assign sum = data_ext;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= i_done;
            if (i_done) s1_data <= sum >>> gp_shift;
        end
    end

    assign s1_wide  = {{(64 - XW){s1_data[XW-1]}}, s1_data};
    assign clip_hi  = (s1_wide > SAT_MAX);
    assign clip_lo  = (s1_wide < SAT_MIN);
    assign sat_data = clip_hi ? SAT_MAX[gp_oup_width-1:0] :
                      clip_lo ? SAT_MIN[gp_oup_width-1:0] :
                                s1_data[gp_oup_width-1:0];

    // Lost only when full and the head is not leaving in the same cycle.
    assign drop_now = s1_valid && fifo_full && !(i_ready && !fifo_empty);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ovf  <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            o_drop <= drop_now;
            if (s1_valid && (clip_hi || clip_lo)) o_ovf <= 1'b1;
        end
    end

    filt_sink_fifo #(
        .WIDTH (gp_oup_width),
        .DEPTH (gp_fifo_depth)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (s1_valid),
        .push_data (sat_data),
        .pop       (i_ready),
        .pop_data  (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

    assign o_valid = !fifo_empty;

endmodule

// File: tb/tb_filt_oup_sink.sv
// tb/tb_filt_oup_sink.sv - scoreboard bench for filt_oup_sink (shift 12, 16-bit out, depth 4)
module tb_filt_oup_sink;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [36:0] i_data = '0;
    logic        i_done = 1'b0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [2:0]  o_level;
    logic        o_ovf;
    logic        o_drop;

    int checks = 0;
    int fails  = 0;
    logic [15:0] sb [$];

    filt_oup_sink dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_done  (i_done),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_level (o_level),
        .o_ovf   (o_ovf),
        .o_drop  (o_drop)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] model(input longint d);
        longint v;
        v = d;
`ifdef FILT_SINK_ROUND_EN
        v = v + 2048;
`endif
        v = v >>> 12;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input longint d, input bit expect_out);
        i_data = 37'(d);
        i_done = 1'b1;
        if (expect_out) sb.push_back(model(d));
    endtask

    // Pops happen at the next rising edge whenever valid&ready is seen here.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL stream_out: unexpected sample %h, none expected", o_data);
            end else begin
                if (o_data !== sb[0]) begin
                    fails++;
                    $display("FAIL stream_out: got %h expected %h", o_data, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        i_ready = 1'b1;
        while ((o_valid || sb.size() != 0) && n < 50) begin
            step;
            n++;
        end
        checks++;
        if (o_valid || sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: valid=%b pending=%0d expected valid=0 pending=0", name, o_valid, sb.size());
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_data = 37'(4096);
            i_done = (c % 2 == 0);
            step;
            checks++;
            if (o_valid !== 1'b0 || o_level !== 3'd0 || o_ovf !== 1'b0 || o_drop !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: valid=%b level=%0d ovf=%b drop=%b expected all 0",
                         o_valid, o_level, o_ovf, o_drop);
            end
        end
        i_rst = 1'b0;
        i_done = 1'b0;
        repeat (3) begin
            step;
            checks++;
            if (o_valid !== 1'b0 || o_data !== 16'h0000) begin
                fails++;
                $display("FAIL reset_done_ignored: valid=%b data=%h expected 0/0000", o_valid, o_data);
            end
        end
    endtask

    task automatic test_scaling;
        longint vals [5];
        vals = '{6144, -6144, 0, 4095, -1};
        for (int i = 0; i < 5; i++) begin
            send(vals[i], 1'b1);
            step;
            i_done = 1'b0;
            checks++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL latency_early: valid=%b expected 0 one edge after done", o_valid);
            end
            step;
            checks++;
            if (o_valid !== 1'b1) begin
                fails++;
                $display("FAIL latency_two_edges: valid=%b expected 1", o_valid);
            end
            drain("scaling");
        end
        checks++;
        if (o_ovf !== 1'b0) begin
            fails++;
            $display("FAIL scaling_no_ovf: ovf=%b expected 0", o_ovf);
        end
    endtask

    task automatic test_saturation;
        send(longint'(1) << 30, 1'b1);
        step;
        send(-(longint'(1) << 30), 1'b1);
        step;
        i_done = 1'b0;
        drain("saturation");
        checks++;
        if (o_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b expected 1", o_ovf);
        end
        send(4096, 1'b1);
        step;
        i_done = 1'b0;
        drain("saturation_after");
        checks++;
        if (o_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: ovf=%b expected 1", o_ovf);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] head;
        head = model(4096);
        i_ready = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 5) send(4096 * longint'(c), c <= 4);
            else i_done = 1'b0;
            step;
            checks++;
            if (o_drop !== (c == 6)) begin
                fails++;
                $display("FAIL bp_drop_c%0d: drop=%b expected %b", c, o_drop, (c == 6));
            end
            if (c >= 2) begin
                checks++;
                if (o_data !== head) begin
                    fails++;
                    $display("FAIL bp_head_stable_c%0d: data=%h expected %h", c, o_data, head);
                end
            end
            if (c >= 5) begin
                checks++;
                if (o_level !== 3'd4) begin
                    fails++;
                    $display("FAIL bp_level_c%0d: level=%0d expected 4", c, o_level);
                end
            end
        end
        drain("backpressure");
    endtask

    task automatic test_full_pop;
        for (int c = 1; c <= 6; c++) begin
            i_ready = (c == 6);
            if (c <= 5) send(4096 * longint'(5 + c), 1'b1);
            else i_done = 1'b0;
            step;
            if (c == 5) begin
                checks++;
                if (o_level !== 3'd4) begin
                    fails++;
                    $display("FAIL fullpop_level_pre: level=%0d expected 4", o_level);
                end
            end
            if (c == 6) begin
                checks++;
                if (o_drop !== 1'b0 || o_level !== 3'd4) begin
                    fails++;
                    $display("FAIL fullpop_same_cycle: drop=%b level=%0d expected 0/4", o_drop, o_level);
                end
            end
        end
        i_done = 1'b0;
        drain("full_pop");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            send(longint'($urandom_range(0, 200000)) - 100000, 1'b1);
            step;
            checks++;
            if (o_drop !== 1'b0) begin
                fails++;
                $display("FAIL b2b_drop_%0d: drop=%b expected 0", i, o_drop);
            end
        end
        i_done = 1'b0;
        drain("back_to_back");
    endtask

    task automatic test_reset_mid;
        i_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            send(4096 * longint'(c), 1'b0);
            step;
        end
        checks++;
        if (o_level !== 3'd3) begin
            fails++;
            $display("FAIL midrst_level_pre: level=%0d expected 3", o_level);
        end
        i_rst = 1'b1;
        send(4096 * 5, 1'b0);
        step;
        i_rst = 1'b0;
        i_done = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_level !== 3'd0 || o_ovf !== 1'b0) begin
            fails++;
            $display("FAIL midrst_cleared: valid=%b level=%0d ovf=%b expected 0/0/0", o_valid, o_level, o_ovf);
        end
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step;
            checks++;
            if (o_valid !== 1'b0 || o_level !== 3'd0) begin
                fails++;
                $display("FAIL midrst_stale_%0d: valid=%b level=%0d expected 0/0", c, o_valid, o_level);
            end
        end
    endtask

    initial begin
        test_reset;
        test_scaling;
        test_saturation;
        test_backpressure;
        test_full_pop;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
